// File: rtl/rename_state.sv
// Rename-stage state: speculative and committed register alias tables plus the physical
// free pool, wrapped around the combinational renamer as a one-stage pipeline to dispatch.
`ifndef PHYS_REGS
`define PHYS_REGS 32
`endif
`ifndef PR_ADDR_W
`define PR_ADDR_W 5
`endif

module rename_state (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [23:0]                 in_microop,
    output logic [`PHYS_REGS-3:0]       ren_free_pool,
    output logic [`PR_ADDR_W*10-1:0]    ren_rat_aliases,
    output logic [9:0]                  ren_rat_mask,
    input  logic [`PHYS_REGS-3:0]       ren_free_pool_after,
    input  logic [`PR_ADDR_W*10-1:0]    ren_new_rat_aliases,
    input  logic [9:0]                  ren_new_rat_mask,
    input  logic [2*`PR_ADDR_W-1:0]     ren_dst_regs,
    input  logic                        ren_valid,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [23:0]                 out_microop,
    output logic [2*`PR_ADDR_W-1:0]     out_dst_regs,
    input  logic [1:0]                  commit_valid,
    input  logic [7:0]                  commit_arch,
    input  logic [2*`PR_ADDR_W-1:0]     commit_phys,
    input  logic                        flush,
    output logic [`PR_ADDR_W:0]         free_count
);
    localparam int NP = `PHYS_REGS - 2;
    localparam int AW = `PR_ADDR_W;
    localparam int NA = 10;

    function automatic logic [AW:0] popcount(input logic [NP-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < NP; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [NP-1:0]      pool_r, pool_s;
    logic [AW*NA-1:0]   spec_alias_r, spec_alias_s;
    logic [NA-1:0]      spec_mask_r, spec_mask_s;
    logic [AW*NA-1:0]   com_alias_r, com_alias_s;
    logic [NA-1:0]      com_mask_r, com_mask_s;
    logic               out_valid_r, out_valid_s;
    logic [23:0]        out_microop_r, out_microop_s;
    logic [2*AW-1:0]    out_dst_r, out_dst_s;
    logic [AW:0]        free_count_r;
    logic [NP-1:0]      release_s, flush_pool_s;
    logic [3:0]         arch_s;
    logic [AW-1:0]      phys_s, old_s, fp_phys_s;
    logic               in_ready_s, fire_s;

    assign in_ready_s = ~flush & ren_valid & (~out_valid_r | out_ready);
    assign fire_s     = in_valid & in_ready_s;

    // Committed RAT update, lane 0 before lane 1, collecting superseded phys registers
    always_comb begin
        com_alias_s = com_alias_r;
        com_mask_s  = com_mask_r;
        release_s   = '0;
        arch_s      = 4'd0;
        phys_s      = '0;
        old_s       = '0;
        for (int l = 0; l < 2; l++) begin
            arch_s = commit_arch[4*l +: 4];
            phys_s = commit_phys[AW*l +: AW];
            if (commit_valid[l] && (arch_s >= 4'd2) && (arch_s <= 4'd9)) begin
                old_s = com_alias_s[AW*arch_s +: AW];
                if (com_mask_s[arch_s] && (old_s >= AW'(2))) begin
                    release_s[old_s - AW'(2)] = 1'b1;
                end else begin
                    release_s = release_s;
                end
                com_alias_s[AW*arch_s +: AW] = phys_s;
                com_mask_s[arch_s]           = 1'b1;
            end else begin
                com_mask_s = com_mask_s;
            end
        end
    end

    // Pool rebuilt on flush: everything free except what the committed RAT still holds
    always_comb begin
        flush_pool_s = '1;
        fp_phys_s    = '0;
        for (int a = 2; a < NA; a++) begin
            fp_phys_s = com_alias_s[AW*a +: AW];
            if (com_mask_s[a] && (fp_phys_s >= AW'(2))) begin
                flush_pool_s[fp_phys_s - AW'(2)] = 1'b0;
            end else begin
                flush_pool_s = flush_pool_s;
            end
        end
    end

    // Speculative RAT and pool next state; released bits never overlap the renamer's pool
    always_comb begin
        pool_s       = pool_r | release_s;
        spec_alias_s = spec_alias_r;
        spec_mask_s  = spec_mask_r;
        if (flush) begin
            pool_s       = flush_pool_s;
            spec_alias_s = com_alias_s;
            spec_mask_s  = com_mask_s;
        end else if (fire_s) begin
            pool_s       = ren_free_pool_after | release_s;
            spec_alias_s = ren_new_rat_aliases;
            spec_mask_s  = ren_new_rat_mask;
        end else begin
            pool_s       = pool_r | release_s;
        end
    end

    // Dispatch-side output register
    always_comb begin
        out_valid_s   = out_valid_r;
        out_microop_s = out_microop_r;
        out_dst_s     = out_dst_r;
        if (flush) begin
            out_valid_s = 1'b0;
        end else if (fire_s) begin
            out_valid_s   = 1'b1;
            out_microop_s = in_microop;
            out_dst_s     = ren_dst_regs;
        end else if (out_ready) begin
            out_valid_s = 1'b0;
        end else begin
            out_valid_s = out_valid_r;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pool_r        <= '1;
            spec_alias_r  <= '0;
            spec_mask_r   <= '0;
            com_alias_r   <= '0;
            com_mask_r    <= '0;
            out_valid_r   <= 1'b0;
            out_microop_r <= 24'd0;
            out_dst_r     <= '0;
            free_count_r  <= (AW+1)'(NP);
        end else begin
            pool_r        <= pool_s;
            spec_alias_r  <= spec_alias_s;
            spec_mask_r   <= spec_mask_s;
            com_alias_r   <= com_alias_s;
            com_mask_r    <= com_mask_s;
            out_valid_r   <= out_valid_s;
            out_microop_r <= out_microop_s;
            out_dst_r     <= out_dst_s;
            free_count_r  <= popcount(pool_s);
        end
    end

    assign in_ready        = in_ready_s;
    assign ren_free_pool   = pool_r;
    assign ren_rat_aliases = spec_alias_r;
    assign ren_rat_mask    = spec_mask_r;
    assign out_valid       = out_valid_r;
    assign out_microop     = out_microop_r;
    assign out_dst_regs    = out_dst_r;
    assign free_count      = free_count_r;
endmodule

// File: tb/tb_rename_state.sv
// Bench for rename_state: a renamer stub feeds the DUT, and a behavioural model of the
// alias tables and free pool (arrays/sets/queue) is compared against every output each cycle.
module tb_rename_state;
    logic        clk, rst_n, in_valid, in_ready, ren_valid, out_valid, out_ready, flush;
    logic [23:0] in_microop, out_microop;
    logic [29:0] ren_free_pool, ren_free_pool_after;
    logic [49:0] ren_rat_aliases, ren_new_rat_aliases;
    logic [9:0]  ren_rat_mask, ren_new_rat_mask, ren_dst_regs, out_dst_regs, commit_phys;
    logic [1:0]  commit_valid;
    logic [7:0]  commit_arch;
    logic [5:0]  free_count;

    rename_state dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_microop(in_microop), .ren_free_pool(ren_free_pool),
        .ren_rat_aliases(ren_rat_aliases), .ren_rat_mask(ren_rat_mask),
        .ren_free_pool_after(ren_free_pool_after), .ren_new_rat_aliases(ren_new_rat_aliases),
        .ren_new_rat_mask(ren_new_rat_mask), .ren_dst_regs(ren_dst_regs), .ren_valid(ren_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_microop(out_microop),
        .out_dst_regs(out_dst_regs), .commit_valid(commit_valid), .commit_arch(commit_arch),
        .commit_phys(commit_phys), .flush(flush), .free_count(free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [29:0] pool;
        logic [49:0] al;
        logic [9:0]  mk;
        logic [9:0]  dst;
    } ren_t;

    typedef struct packed {
        logic [3:0] a;
        logic [4:0] p;
    } pend_t;

    // Renamer behaviour: dest arch in uop[15:12] (lane 0) and uop[19:16] (lane 1), valid when 2..9;
    // each takes the lowest free phys register.
    function automatic ren_t ren_fn(logic [29:0] pool, logic [49:0] al, logic [9:0] mk, logic [23:0] uop);
        ren_t r;
        logic [3:0] a;
        int p;
        r.valid = 1'b1; r.pool = pool; r.al = al; r.mk = mk; r.dst = '0;
        for (int l = 0; l < 2; l++) begin
            a = uop[12+4*l +: 4];
            if (a >= 4'd2 && a <= 4'd9) begin
                p = -1;
                for (int i = 0; i < 30; i++) if (p < 0 && r.pool[i]) p = i;
                if (p < 0) r.valid = 1'b0;
                else begin
                    r.pool[p] = 1'b0;
                    r.al[a*5 +: 5] = 5'(p + 2);
                    r.mk[a] = 1'b1;
                    r.dst[l*5 +: 5] = 5'(p + 2);
                end
            end
        end
        return r;
    endfunction

    ren_t stub;
    assign stub                = ren_fn(ren_free_pool, ren_rat_aliases, ren_rat_mask, in_microop);
    assign ren_valid           = stub.valid;
    assign ren_free_pool_after = stub.pool;
    assign ren_new_rat_aliases = stub.al;
    assign ren_new_rat_mask    = stub.mk;
    assign ren_dst_regs        = stub.dst;

    // Behavioural model: m_free bit p means phys p is free
    logic [31:0] m_free;
    int          m_spec[10], m_com[10];
    bit          m_smask[10], m_cmask[10];
    bit          m_ov;
    logic [23:0] m_ouop;
    logic [9:0]  m_odst;
    pend_t       pend[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [49:0] pack_spec();
        logic [49:0] v = '0;
        for (int a = 0; a < 10; a++) v[5*a +: 5] = 5'(m_spec[a]);
        return v;
    endfunction

    function automatic logic [9:0] pack_smask();
        logic [9:0] v = '0;
        for (int a = 0; a < 10; a++) v[a] = m_smask[a];
        return v;
    endfunction

    task automatic model_reset();
        m_free = 32'hFFFF_FFFC;
        for (int a = 0; a < 10; a++) begin
            m_spec[a] = 0; m_com[a] = 0; m_smask[a] = 1'b0; m_cmask[a] = 1'b0;
        end
        m_ov = 1'b0; m_ouop = 24'd0; m_odst = 10'd0;
        pend.delete();
    endtask

    task automatic model_step();
        ren_t r;
        logic [31:0] rel;
        bit fire;
        int a, p;
        logic [3:0] da;
        r = ren_fn(m_free[31:2], pack_spec(), pack_smask(), in_microop);
        fire = in_valid && !flush && r.valid && (!m_ov || out_ready);
        rel = 32'd0;
        for (int l = 0; l < 2; l++) begin
            a = int'(commit_arch[4*l +: 4]);
            p = int'(commit_phys[5*l +: 5]);
            if (commit_valid[l] && a >= 2 && a <= 9) begin
                if (m_cmask[a] && m_com[a] >= 2) rel[m_com[a]] = 1'b1;
                m_com[a] = p;
                m_cmask[a] = 1'b1;
            end
        end
        if (flush) begin
            m_spec = m_com;
            m_smask = m_cmask;
            m_free = 32'hFFFF_FFFC;
            for (int k = 2; k < 10; k++) if (m_cmask[k] && m_com[k] >= 2) m_free[m_com[k]] = 1'b0;
            m_ov = 1'b0;
            pend.delete();
        end else begin
            if (fire) begin
                m_free = {r.pool, 2'b00};
                for (int k = 0; k < 10; k++) begin
                    m_spec[k] = int'(r.al[5*k +: 5]);
                    m_smask[k] = r.mk[k];
                end
                m_ov = 1'b1; m_ouop = in_microop; m_odst = r.dst;
                for (int l = 0; l < 2; l++) begin
                    da = in_microop[12+4*l +: 4];
                    if (da >= 4'd2 && da <= 4'd9) pend.push_back('{a: da, p: r.dst[5*l +: 5]});
                end
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            m_free = m_free | rel;
        end
    endtask

    // Every-cycle comparison of all DUT outputs against the model
    ren_t cr;
    always @(negedge clk) begin
        cr = ren_fn(m_free[31:2], pack_spec(), pack_smask(), in_microop);
        chk("in_ready", 64'(in_ready), 64'(!flush && cr.valid && (!m_ov || out_ready)));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_microop", 64'(out_microop), 64'(m_ouop));
        chk("out_dst_regs", 64'(out_dst_regs), 64'(m_odst));
        chk("ren_free_pool", 64'(ren_free_pool), 64'(m_free[31:2]));
        chk("ren_rat_aliases", 64'(ren_rat_aliases), 64'(pack_spec()));
        chk("ren_rat_mask", 64'(ren_rat_mask), 64'(pack_smask()));
        chk("free_count", 64'(free_count), 64'($countones(m_free)));
    end

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_microop = 24'd0; out_ready = 1'b1; flush = 1'b0;
        commit_valid = 2'b00; commit_arch = 8'd0; commit_phys = 10'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        idle_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic commit_pop(int n);
        pend_t pe;
        commit_valid = 2'b00;
        for (int l = 0; l < n; l++) begin
            if (pend.size() > 0) begin
                pe = pend.pop_front();
                commit_valid[l] = 1'b1;
                commit_arch[4*l +: 4] = pe.a;
                commit_phys[5*l +: 5] = pe.p;
            end
        end
        step();
        commit_valid = 2'b00;
    endtask

    logic [49:0] exp_al;
    logic [23:0] uops[4];
    pend_t       rpe;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        do_reset();
        #1;
        chk("rst_free_count", 64'(free_count), 64'd30);
        chk("rst_pool", 64'(ren_free_pool), 64'h3FFF_FFFF);
        chk("rst_mask", 64'(ren_rat_mask), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);

        // First rename: two dests, arch 2 and 3
        in_valid = 1'b1; in_microop = 24'h023000; out_ready = 1'b1; #1;
        chk("s1_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0; #1;
        chk("s1_out_valid", 64'(out_valid), 64'd1);
        chk("s1_free_count", 64'(free_count), 64'd28);
        chk("s1_mask", 64'(ren_rat_mask), 64'h00C);
        chk("s1_dst", 64'(out_dst_regs), 64'h062);

        // Back-pressure: output held, second op waits for out_ready
        out_ready = 1'b0; in_valid = 1'b1; in_microop = 24'h045000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("s2_in_ready_low", 64'(in_ready), 64'd0);
            chk("s2_out_held", 64'(out_microop), 64'h023000);
            step();
        end
        out_ready = 1'b1; #1;
        chk("s2_in_ready_high", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0; #1;
        chk("s2_second_out", 64'(out_microop), 64'h045000);

        // Arch 4 renamed twice, commits release only on the second
        do_reset();
        in_valid = 1'b1; in_microop = 24'h004000;
        step(); step();
        in_valid = 1'b0; #1;
        chk("s3_free_count", 64'(free_count), 64'd28);
        commit_pop(1); #1;
        chk("s3_after_a", 64'(free_count), 64'd28);
        chk("s3_bit_a_clear", 64'(ren_free_pool[0]), 64'd0);
        commit_pop(1); #1;
        chk("s3_after_b", 64'(free_count), 64'd29);
        chk("s3_bit_a_set", 64'(ren_free_pool[0]), 64'd1);

        // Same-arch two-lane commit: W and X released
        do_reset();
        in_valid = 1'b1; in_microop = 24'h005000;
        step(); step(); step();
        in_valid = 1'b0; #1;
        chk("s4_free_count", 64'(free_count), 64'd27);
        commit_pop(1); #1;
        chk("s4_after_w", 64'(free_count), 64'd27);
        commit_pop(2); #1;
        chk("s4_after_xy", 64'(free_count), 64'd29);
        chk("s4_released", 64'(ren_free_pool[1:0]), 64'd3);

        // Exhaust the pool, then a release un-stalls
        do_reset();
        in_valid = 1'b1; in_microop = 24'h023000;
        for (int i = 0; i < 15; i++) step();
        #1;
        chk("s5_empty", 64'(free_count), 64'd0);
        chk("s5_stall", 64'(in_ready), 64'd0);
        step();
        commit_pop(2); #1;
        chk("s5_still_stall", 64'(in_ready), 64'd0);
        commit_pop(2); #1;
        chk("s5_unstall", 64'(in_ready), 64'd1);
        chk("s5_count", 64'(free_count), 64'd2);
        in_valid = 1'b0;

        // Flush together with a commit
        do_reset();
        uops[0] = 24'h023000; uops[1] = 24'h045000; uops[2] = 24'h067000; uops[3] = 24'h089000;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_microop = uops[i];
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        commit_pop(2);
        commit_pop(2);
        flush = 1'b1;
        commit_pop(2);
        flush = 1'b0; out_ready = 1'b1; #1;
        exp_al = {5'd0, 5'd0, 5'd6, 5'd7, 5'd4, 5'd5, 5'd2, 5'd3, 5'd0, 5'd0};
        chk("s6_out_valid", 64'(out_valid), 64'd0);
        chk("s6_mask", 64'(ren_rat_mask), 64'h0FC);
        chk("s6_aliases", 64'(ren_rat_aliases), 64'(exp_al));
        chk("s6_free_count", 64'(free_count), 64'd24);

        // Randomized traffic with in-order commits, flushes and one mid-run reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_microop = 24'($urandom);
            in_microop[15:12] = 4'($urandom_range(0, 11));
            in_microop[19:16] = 4'($urandom_range(0, 11));
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 49) == 0);
            commit_valid = 2'b00;
            if ($urandom_range(0, 15) == 0) begin
                commit_valid[0] = 1'b1;
                commit_arch[3:0] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(10, 15));
                commit_phys[4:0] = 5'($urandom);
            end else if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                rpe = pend.pop_front();
                commit_valid[0] = 1'b1; commit_arch[3:0] = rpe.a; commit_phys[4:0] = rpe.p;
            end
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                rpe = pend.pop_front();
                commit_valid[1] = 1'b1; commit_arch[7:4] = rpe.a; commit_phys[9:5] = rpe.p;
            end
            if (i == 1500) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                idle_inputs();
                step();
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        idle_inputs();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
